// File: rtl/instruction_fetch.sv
// Instruction fetch front end: in-order word reads over a req/gnt/rvalid bus, a small
// {pc, inst} queue toward execution, and redirect handling that drops wrong-path data.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        inst_v_o,
    output logic [31:0] inst_o
);
    localparam int QAW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] QDEPTH_U = 32'(QUEUE_DEPTH);
    localparam logic [31:0] MAXO_U   = 32'(MAX_OUTSTANDING);

    logic [31:0]    fpc_q, fpc_d;
    logic [31:0]    q_pc_q   [QUEUE_DEPTH];
    logic [31:0]    q_inst_q [QUEUE_DEPTH];
    logic [QAW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [QCW-1:0] q_cnt_q, q_cnt_d;
    logic [31:0]    pf_pc_q  [MAX_OUTSTANDING];
    logic [OAW-1:0] pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
    logic [OCW-1:0] live_q, live_d, discard_q, discard_d;

    logic grant, resp_keep, resp_drop, pop;

    function automatic logic [OAW-1:0] pf_next(input logic [OAW-1:0] ptr);
        return (ptr == OAW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + OAW'(1);
    endfunction

    // Credit counts live requests against queue space so a response always has a slot.
    assign imem_req_o  = !reset && !redirect_v_i
                         && (32'(live_q) + 32'(discard_q) < MAXO_U)
                         && (32'(live_q) + 32'(q_cnt_q) < QDEPTH_U);
    assign imem_addr_o = fpc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    assign resp_drop   = imem_rvalid_i && !redirect_v_i && (discard_q != '0);
    assign resp_keep   = imem_rvalid_i && !redirect_v_i && (discard_q == '0);

    assign inst_v_o = !reset && !redirect_v_i && (q_cnt_q != '0);
    assign pop      = inst_v_o;
    assign pc_o     = q_pc_q[q_rd_q];
    assign inst_o   = q_inst_q[q_rd_q];

    always_comb begin
        fpc_d     = fpc_q;
        live_d    = live_q;
        discard_d = discard_q;
        q_cnt_d   = q_cnt_q;
        q_rd_d    = q_rd_q;
        q_wr_d    = q_wr_q;
        pf_rd_d   = pf_rd_q;
        pf_wr_d   = pf_wr_q;
        if (redirect_v_i) begin
            // Everything still in flight becomes wrong-path; a response landing now is dropped too.
            fpc_d     = {redirect_pc_i[31:2], 2'b00};
            live_d    = '0;
            discard_d = discard_q + live_q - OCW'(imem_rvalid_i);
            q_cnt_d   = '0;
            q_rd_d    = '0;
            q_wr_d    = '0;
            pf_rd_d   = '0;
            pf_wr_d   = '0;
        end else begin
            if (grant) begin
                fpc_d   = fpc_q + 32'd4;
                pf_wr_d = pf_next(pf_wr_q);
            end
            if (resp_drop) discard_d = discard_q - OCW'(1);
            if (resp_keep) begin
                pf_rd_d = pf_next(pf_rd_q);
                q_wr_d  = q_wr_q + QAW'(1);
            end
            if (pop) q_rd_d = q_rd_q + QAW'(1);
            live_d  = live_q + OCW'(grant) - OCW'(resp_keep);
            q_cnt_d = q_cnt_q + QCW'(resp_keep) - QCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q     <= RESET_PC;
            live_q    <= '0;
            discard_q <= '0;
            q_cnt_q   <= '0;
            q_rd_q    <= '0;
            q_wr_q    <= '0;
            pf_rd_q   <= '0;
            pf_wr_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) pf_pc_q[i] <= '0;
        end else begin
            fpc_q     <= fpc_d;
            live_q    <= live_d;
            discard_q <= discard_d;
            q_cnt_q   <= q_cnt_d;
            q_rd_q    <= q_rd_d;
            q_wr_q    <= q_wr_d;
            pf_rd_q   <= pf_rd_d;
            pf_wr_q   <= pf_wr_d;
            if (grant) pf_pc_q[pf_wr_q] <= fpc_q;
            if (resp_keep) begin
                q_pc_q[q_wr_q]   <= pf_pc_q[pf_rd_q];
                q_inst_q[q_wr_q] <= imem_rdata_i;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(resp_keep && !pop && (32'(q_cnt_q) == QDEPTH_U)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid_i |-> ((live_q != '0) || (discard_q != '0)));
endmodule
